// File: rtl/uart_tx_fifo_if.sv
// CPU store-path strobe/data and transmitter status, bundled for the serial port.
// The CPU side uses the master modport; the transmitter uses the slave modport.
interface uart_tx_fifo_if #(
  parameter int CNT_W = 3
);
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             txd;
  logic             tbre;
  logic             tsre;
  logic             full;
  logic [CNT_W-1:0] level;

  modport master (
    output wr_en,
    output wr_data,
    input  txd,
    input  tbre,
    input  tsre,
    input  full,
    input  level
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output txd,
    output tbre,
    output tsre,
    output full,
    output level
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 serial transmitter fed by a DEPTH-byte FIFO; first start bit one edge after a write to an empty FIFO.
// No backpressure: a write while full is silently dropped, full/level let the CPU pace itself.
module uart_tx_fifo #(
  parameter int CLK_DIV = 16,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 3
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int BAUD_W = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  level;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              txd;

  logic full;
  logic bit_end;
  logic push;
  logic pop;

  // full uses pre-edge occupancy, so a write is dropped even if a pop shares the edge
  assign full    = (level == CNT_W'(DEPTH));
  assign bit_end = (baud_cnt == BAUD_W'(CLK_DIV - 1));
  assign push    = bus.wr_en && !full;
  assign pop     = (level != '0) && ((state == IDLE) || (state == STOP && bit_end));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level <= level + CNT_W'(1);
      end else if (pop && !push) begin
        level <= level - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      txd      <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      baud_cnt <= bit_end ? '0 : baud_cnt + BAUD_W'(1);
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            txd   <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_idx <= '0;
            txd     <= shift[0];
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shift[bit_idx + 3'd1];
            end
          end
        end
        STOP: begin
          // Back-to-back frames: the next start bit follows the stop bit directly
          if (bit_end) begin
            if (pop) begin
              shift <= mem[rd_ptr];
              txd   <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.txd   = txd;
  assign bus.tbre  = (level == '0);
  assign bus.tsre  = (state == IDLE);
  assign bus.full  = full;
  assign bus.level = level;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized and directed stimulus for uart_tx_fifo, checked against a queue/timer model
// and a frame-decoding monitor that pops expected bytes from a scoreboard.
module tb_uart_tx_fifo;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 3;
  localparam int FRAME   = 10 * CLK_DIV;
  localparam int SB_SZ   = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_fifo_if #(.CNT_W(CNT_W)) bus ();

  uart_tx_fifo #(
    .CLK_DIV(CLK_DIV),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes waiting in the FIFO, plus cycles left in the frame on the wire
  logic [7:0] fq[$];
  int         rem      = 0;
  logic [7:0] cur      = '0;
  int         epoch    = 0;
  int         rst_mark = 0;
  int         exp_wr   = 0;
  int         dropped  = 0;
  bit         started  = 1'b0;
  logic [7:0] exp_mem [SB_SZ];

  always @(posedge clk) begin
    int pre;
    bit do_pop;
    if (rst) begin
      fq.delete();
      rem      = 0;
      epoch++;
      rst_mark = exp_wr;
      started  = 1'b1;
    end else if (started) begin
      pre    = fq.size();
      do_pop = (pre > 0) && (rem <= 1);
      if (do_pop) begin
        cur = fq.pop_front();
        rem = FRAME;
      end else if (rem > 0) begin
        rem--;
      end
      if (bus.wr_en === 1'b1) begin
        if (pre < DEPTH) begin
          fq.push_back(bus.wr_data);
          exp_mem[exp_wr % SB_SZ] = bus.wr_data;
          exp_wr++;
        end else begin
          dropped++;
        end
      end
    end
  end

  function automatic logic exp_txd();
    int b;
    if (rem == 0) return 1'b1;
    b = (FRAME - rem) / CLK_DIV;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[b-1];
  endfunction

  // Status checks every cycle plus frame decoder feeding the scoreboard
  int         mon_pos   = -1;
  int         mon_epoch = 0;
  int         exp_rd    = 0;
  int         frame_cnt = 0;
  logic [9:0] mbits     = '0;
  bit         mok       = 1'b1;

  always @(negedge clk) begin
    int b;
    if (started) begin
      check("level", 32'(bus.level), fq.size());
      check("tbre", 32'(bus.tbre), 32'(fq.size() == 0));
      check("full", 32'(bus.full), 32'(fq.size() == DEPTH));
      check("tsre", 32'(bus.tsre), 32'(rem == 0));
      check("txd", 32'(bus.txd), 32'(exp_txd()));

      if (mon_epoch != epoch) begin
        mon_epoch = epoch;
        mon_pos   = -1;
        exp_rd    = rst_mark;
      end
      if (mon_pos < 0 && bus.txd === 1'b0) begin
        mon_pos = 0;
        mok     = 1'b1;
        mbits   = '0;
      end
      if (mon_pos >= 0) begin
        b = mon_pos / CLK_DIV;
        if (mon_pos % CLK_DIV == 0) mbits[b] = bus.txd;
        else if (bus.txd !== mbits[b]) mok = 1'b0;
        mon_pos++;
        if (mon_pos == FRAME) begin
          frame_cnt++;
          check("frame_shape", 32'(mok && mbits[0] == 1'b0 && mbits[9] == 1'b1), 1);
          if (exp_rd >= exp_wr) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got byte %0h, expected no frame at %0t", mbits[8:1], $time);
          end else begin
            check("frame_data", 32'(mbits[8:1]), 32'(exp_mem[exp_rd % SB_SZ]));
            exp_rd++;
          end
          mon_pos = -1;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    cyc(1);
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'($urandom);
  endtask

  task automatic wait_rem(input string name, input int target);
    int n = 0;
    while (rem != target && n < 2000) begin
      cyc(1);
      n++;
    end
    check({name, "_wait_in_budget"}, 32'(n < 2000), 1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((fq.size() != 0 || rem != 0) && n < 4000) begin
      cyc(1);
      n++;
    end
    check({name, "_drain_in_budget"}, 32'(n < 4000), 1);
    cyc(2);
    check({name, "_frames_out"}, exp_rd, exp_wr);
  endtask

  initial begin
    logic [9:0]  t1_bits;
    logic [7:0]  t2_data [6];
    int          f0;
    int          n;

    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    rst         = 1'b1;
    cyc(3);
    rst = 1'b0;
    check("reset_txd", 32'(bus.txd), 1);
    check("reset_tbre", 32'(bus.tbre), 1);
    check("reset_tsre", 32'(bus.tsre), 1);
    check("reset_full", 32'(bus.full), 0);
    check("reset_level", 32'(bus.level), 0);
    cyc(2);

    // Single byte 0xA5: start, LSB..MSB, stop
    t1_bits = 10'b1101001010;
    write(8'hA5);
    check("t1_level_after_write", 32'(bus.level), 1);
    check("t1_tbre_after_write", 32'(bus.tbre), 0);
    cyc(1);
    check("t1_txd_fall", 32'(bus.txd), 0);
    check("t1_tbre_popped", 32'(bus.tbre), 1);
    check("t1_tsre_busy", 32'(bus.tsre), 0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t1_bit%0d", i), 32'(bus.txd), 32'(t1_bits[i]));
      cyc(CLK_DIV);
    end
    check("t1_tsre_done", 32'(bus.tsre), 1);
    drain("t1");

    // Five accepted back-to-back writes, sixth dropped while full
    f0 = frame_cnt;
    t2_data[0] = 8'h01; t2_data[1] = 8'h02; t2_data[2] = 8'h03;
    t2_data[3] = 8'h04; t2_data[4] = 8'hFF; t2_data[5] = 8'hEE;
    for (int i = 0; i < 6; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = t2_data[i];
      cyc(1);
      if (i == 3) check("t2_level_before_fifth", 32'(bus.level), 3);
      if (i == 4) check("t2_full_after_fifth", 32'(bus.full), 1);
    end
    bus.wr_en = 1'b0;
    check("t2_level_after_drop", 32'(bus.level), 4);
    drain("t2");
    check("t2_frame_count", frame_cnt - f0, 5);

    // Write exactly at the STOP->START pop edge while full
    for (int i = 0; i < 5; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h10 + i);
      cyc(1);
    end
    bus.wr_en = 1'b0;
    check("t3_full", 32'(bus.full), 1);
    wait_rem("t3", 1);
    write(8'h3C);
    check("t3_level_after_pop", 32'(bus.level), 3);
    check("t3_not_full", 32'(bus.full), 0);
    drain("t3");

    // Reset at the start of data bit 3 of 0x55 with two bytes queued
    write(8'h55);
    write(8'h66);
    write(8'h77);
    check("t4_level_queued", 32'(bus.level), 2);
    wait_rem("t4", FRAME - 4 * CLK_DIV);
    f0  = frame_cnt;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("t4_txd", 32'(bus.txd), 1);
    check("t4_level", 32'(bus.level), 0);
    check("t4_tbre", 32'(bus.tbre), 1);
    check("t4_tsre", 32'(bus.tsre), 1);
    cyc(3 * FRAME);
    check("t4_no_frames", frame_cnt - f0, 0);

    // Two frames back to back: total length is twice the frame length
    write(8'h80);
    write(8'h7F);
    n = 0;
    while (bus.txd !== 1'b0 && n < 100) begin
      cyc(1);
      n++;
    end
    check("t5_start_seen", 32'(n < 100), 1);
    n = 0;
    while (bus.tsre !== 1'b1 && n < 1000) begin
      cyc(1);
      n++;
    end
    check("t5_two_frame_cycles", n, 2 * FRAME);
    drain("t5");

    // Push and pop on the same edge keep level steady
    write(8'hA1);
    write(8'hB2);
    write(8'hC3);
    check("t6_level_two", 32'(bus.level), 2);
    wait_rem("t6", 1);
    write(8'hD4);
    check("t6_level_kept", 32'(bus.level), 2);
    drain("t6");

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      bus.wr_en   = ($urandom_range(0, 99) < 30);
      bus.wr_data = 8'($urandom);
      rst         = ($urandom_range(0, 999) == 0);
      cyc(1);
    end
    bus.wr_en = 1'b0;
    rst       = 1'b0;
    drain("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Serial transmitter for the CPU's memory-mapped serial port. It is the transmit counterpart of the existing receive path.
- A store to the serial data address pushes one byte into a small FIFO. The block sends the bytes out on `txd` as 8N1 frames, LSB first.
- The `tbre`/`tsre` status flags are read by the CPU's status-register polling loop.
- Sits beside the memory/peripheral controller under `top` and runs on the CPU clock.

Parameters:
- `CLK_DIV`, 16, CPU clock cycles per serial bit. Must be ≥2.
- `DEPTH`, 4, FIFO depth in bytes. Must be a power of two, ≥2.
- `CNT_W`, 3, width of the `level` output. Equals log2(`DEPTH`)+1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge
- `rst`  in  1  synchronous reset, active-high
- `wr_en`  in  1  one-cycle write strobe from the CPU store path
- `wr_data`  in  8  byte to transmit
- `txd`  out  1  serial line; idle high
- `tbre`  out  1  transmit buffer empty (FIFO holds 0 bytes)
- `tsre`  out  1  transmit shift register empty (FSM in IDLE)
- `full`  out  1  FIFO holds `DEPTH` bytes
- `level`  out  `CNT_W`  current FIFO occupancy, 0..`DEPTH`

Behaviour:
- Reset (synchronous, `rst`=1 at a rising edge):
  - `txd`=1, `tbre`=1, `tsre`=1, `full`=0, `level`=0.
  - FSM goes to IDLE; FIFO pointers, baud counter and bit index clear.
  - Reset mid-frame abandons the frame: `txd` returns to 1 at that edge and queued bytes are discarded.
- FIFO write:
  - Byte is stored at the edge where `wr_en`=1 and `full`=0.
  - `wr_en` while `full`=1 is dropped silently. No pointer or level change.
  - `full` is evaluated on the pre-edge occupancy. A write while full is dropped even if a pop occurs at the same edge.
- FIFO pop:
  - Occurs only at the IDLE→START or STOP→START transition.
  - Simultaneous push and pop with 0 < `level` < `DEPTH` leaves `level` unchanged.
  - Pointers wrap modulo `DEPTH`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `txd`=1.
    - If `level` > 0 at an edge: pop the head byte into the shift register, clear the baud counter, enter START.
    - A write to an empty FIFO in cycle N is popped at edge N+1. `txd` falls at that edge.
  - START: `txd`=0 for exactly `CLK_DIV` cycles, then enter DATA with bit index 0.
  - DATA: `txd`=shift[idx] for exactly `CLK_DIV` cycles per bit, idx 0..7 (LSB first). After idx 7, enter STOP.
  - STOP: `txd`=1 for exactly `CLK_DIV` cycles.
    - At the end, if `level` > 0: pop and go directly to START (back-to-back frames, no extra idle).
    - Otherwise enter IDLE.
- Frame length is exactly 10×`CLK_DIV` cycles.
- `txd` is registered: no combinational path from inputs.
- Baud counter counts 0..`CLK_DIV`-1 and wraps at each bit boundary.
- Flags, all registered/derived from registered state with no extra latency:
  - `tsre` = (state==IDLE).
  - `tbre` = (`level`==0).
  - `full` = (`level`==`DEPTH`).
  - A single queued byte gives `tbre`=1 one edge after the write (it has already been popped), while `tsre`=0 until its stop bit ends.
- `wr_data` is sampled only on an accepted write. Later changes do not affect queued bytes.

Test Plan:
1. `CLK_DIV`=4, reset, then `wr_en` with 0xA5 for one cycle:
   - `txd` falls one edge later.
   - Bits over 40 cycles are 0,1,0,1,0,0,1,0,1,1 (start, LSB..MSB, stop).
   - `tsre` returns to 1 after cycle 40; `tbre` is 1 from the edge after the write.
2. Four back-to-back writes 0x01,0x02,0x03,0x04, then a fifth write 0xFF on the next cycle:
   - 0xFF is accepted (first byte already popped, `level` 3).
   - A sixth write on the next cycle sees `full`=1 and is dropped.
   - `txd` shows five consecutive frames with no idle gap and never shows a sixth frame.
3. Fill the FIFO (`level`=4, `full`=1) and assert `wr_en` on the exact edge of the STOP→START pop:
   - Write dropped; `level` becomes 3.
4. Assert `rst` for one cycle at the start of DATA bit 3 of 0x55 with 2 bytes queued:
   - Next edge: `txd`=1, `level`=0, `tbre`=1, `tsre`=1.
   - No further frames are sent.
5. Write 0x80 then 0x7F at `CLK_DIV`=16:
   - Exactly 320 cycles from first `txd` fall to final stop-bit end.
   - Second start bit begins on the cycle immediately after the first stop bit.
6. Push/pop coincidence: with `level`=2 during STOP of frame 1, write at the final stop cycle:
   - `level` remains 2 across that edge.
   - The byte order out is preserved.
